// File: rtl/string_top.sv
// Moore detector for the symbol pattern 11,11,01,11 on sym = {a,b} while start is high.
// Define STRING_TOP_OVERLAP_EN to let a trailing 11 seed the next match.
module string_top (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic a,
  input  logic b,
  output logic y_val
);

  localparam int unsigned SYM_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    G1    = 3'd1,
    G2    = 3'd2,
    G3    = 3'd3,
    MATCH = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               y_val_q, y_val_d;
  logic [SYM_W-1:0]   sym;

  assign sym   = {a, b};
  assign y_val = y_val_q;

  // State and match-flag registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      y_val_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_val_q <= y_val_d;
    end
  end

  // Next-state logic; flag is computed from the next state so it tracks MATCH exactly.
  always_comb begin
    state_d = IDLE;
    y_val_d = 1'b0;
    if (start) begin
      unique case (state_q)
        IDLE:  state_d = (sym == 2'b11) ? G1 : IDLE;
        G1:    state_d = (sym == 2'b11) ? G2 : IDLE;
        G2: begin
          if (sym == 2'b01)      state_d = G3;
          else if (sym == 2'b11) state_d = G2;
          else                   state_d = IDLE;
        end
        G3:    state_d = (sym == 2'b11) ? MATCH : IDLE;
`ifdef STRING_TOP_OVERLAP_EN
        MATCH: state_d = (sym == 2'b11) ? G2 : IDLE;
`else
        MATCH: state_d = (sym == 2'b11) ? G1 : IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
    y_val_d = (state_d == MATCH);
  end

endmodule

// File: tb/tb_string_top.sv
// Directed bench for string_top: expected y_val pushed per step, popped and checked after the edge.
module tb_string_top;

  logic clk;
  logic reset;
  logic start;
  logic a;
  logic b;
  logic y_val;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic        exp_q[$];

`ifdef STRING_TOP_OVERLAP_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif

  string_top dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .y_val (y_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the expected flag, check it 1 time unit after the edge.
  task automatic step(input logic rst_v, input logic st_v, input logic [1:0] sym_v,
                      input logic exp_v, input string tag);
    logic e;
    reset = rst_v;
    start = st_v;
    a     = sym_v[1];
    b     = sym_v[0];
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      assert (y_val === e) else begin
        tests_failed++;
        $error("FAIL %s y_val observed=%0b expected=%0b", tag, y_val, e);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    logic [2:0] st;
    st = 3'(dut.state_q);
    tests_run++;
    assert (st === 3'd0) else begin
      tests_failed++;
      $error("FAIL %s state observed=%0d expected=0", tag, st);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    start = 1'b0;
    a     = 1'b0;
    b     = 1'b0;

    // Reset, then constant 11 stream must never match
    step(1'b0, 1'b1, 2'b11, 1'b0, "reset");
    check_idle("reset_state");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'b11, 1'b0, "const11");

    // Single match, one-cycle pulse
    step(1'b1, 1'b0, 2'b00, 1'b0, "clr1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "m1_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "m1_s2");
    step(1'b1, 1'b1, 2'b01, 1'b0, "m1_s3");
    step(1'b1, 1'b1, 2'b11, 1'b1, "m1_s4");
    step(1'b1, 1'b1, 2'b00, 1'b0, "m1_after");

    // Back-to-back sequence: overlap gives a second pulse
    step(1'b1, 1'b0, 2'b00, 1'b0, "clr2");
    step(1'b1, 1'b1, 2'b11, 1'b0, "ov_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "ov_s2");
    step(1'b1, 1'b1, 2'b01, 1'b0, "ov_s3");
    step(1'b1, 1'b1, 2'b11, 1'b1, "ov_s4");
    step(1'b1, 1'b1, 2'b11, 1'b0, "ov_s5");
    step(1'b1, 1'b1, 2'b01, 1'b0, "ov_s6");
    step(1'b1, 1'b1, 2'b11, OVL,  "ov_s7");
    step(1'b1, 1'b1, 2'b00, 1'b0, "ov_after");

    // start=0 clears partial match
    step(1'b1, 1'b1, 2'b11, 1'b0, "st_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "st_s2");
    step(1'b1, 1'b1, 2'b01, 1'b0, "st_s3");
    step(1'b1, 1'b0, 2'b11, 1'b0, "st_hold");
    step(1'b1, 1'b1, 2'b11, 1'b0, "st_s4");
    step(1'b1, 1'b1, 2'b00, 1'b0, "st_after");

    // Reset mid-pattern, then first symbol after release starts a pattern
    step(1'b1, 1'b1, 2'b11, 1'b0, "rm_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "rm_s2");
    step(1'b1, 1'b1, 2'b01, 1'b0, "rm_s3");
    step(1'b0, 1'b1, 2'b11, 1'b0, "rm_rst");
    check_idle("rm_state");
    step(1'b1, 1'b1, 2'b11, 1'b0, "pr_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "pr_s2");
    step(1'b1, 1'b1, 2'b01, 1'b0, "pr_s3");
    step(1'b1, 1'b1, 2'b11, 1'b1, "pr_s4");

    // Reset in MATCH
    step(1'b0, 1'b1, 2'b11, 1'b0, "mr_rst");
    check_idle("mr_state");

    // start=0 in MATCH
    step(1'b1, 1'b1, 2'b11, 1'b0, "ms_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "ms_s2");
    step(1'b1, 1'b1, 2'b01, 1'b0, "ms_s3");
    step(1'b1, 1'b1, 2'b11, 1'b1, "ms_s4");
    step(1'b1, 1'b0, 2'b11, 1'b0, "ms_stop");
    check_idle("ms_state");

    // G2 self-loop: 11,11,11,01,11
    step(1'b1, 1'b1, 2'b11, 1'b0, "sl_s1");
    step(1'b1, 1'b1, 2'b11, 1'b0, "sl_s2");
    step(1'b1, 1'b1, 2'b11, 1'b0, "sl_s3");
    step(1'b1, 1'b1, 2'b01, 1'b0, "sl_s4");
    step(1'b1, 1'b1, 2'b11, 1'b1, "sl_s5");
    step(1'b1, 1'b1, 2'b10, 1'b0, "sl_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/string_top.md
STRING_TOP -- requirements
Module: string_top

Interface
REQ-001 The block SHALL have one clock and reset that is synchronous and active-low, ports named clk and reset.
REQ-002 Ports (clock and reset first):
- clk    input   1  rising-edge clock
- reset  input   1  synchronous active-low reset
- start  input   1  enable; 1 = match, 0 = hold in IDLE
- a      input   1  symbol MSB
- b      input   1  symbol LSB
- y_val  output  1  registered match flag, Moore
REQ-003 The block SHALL have no parameters; the pattern is fixed in RTL.

Function
REQ-004 Each cycle SHALL form the symbol sym = {a,b}, sampled at the rising clk edge.
REQ-005 The block SHALL detect the 4-symbol pattern 11, 11, 01, 11 on consecutive cycles while start=1.
REQ-006 The FSM SHALL have the states IDLE, G1 (11 seen), G2 (11,11), G3 (11,11,01) and MATCH, stored in a 3-bit binary state register.
REQ-007 Transitions when start=1:
- IDLE: 11 -> G1; any other symbol -> IDLE
- G1: 11 -> G2; any other symbol -> IDLE
- G2: 01 -> G3; 11 -> G2; 00 or 10 -> IDLE
- G3: 11 -> MATCH; any other symbol -> IDLE
- MATCH: depends on the configuration (REQ-015/016)
REQ-008 If start=0 at a rising edge, next state SHALL be IDLE, clearing any partial match; start=0 in MATCH also SHALL go to IDLE.
REQ-009 y_val SHALL be 1 exactly when the state is MATCH, and 0 otherwise.
REQ-010 Latency: the 4th pattern symbol, sampled at edge k, SHALL make y_val=1 from edge k until edge k+1 (one cycle wide per match).
REQ-011 A constant 11 stream SHALL hold the state in G2 and never assert y_val.
REQ-012 Unreachable state encodings SHALL go to IDLE on the next edge, with y_val=0.

Reset
REQ-013 reset=0 at a rising edge SHALL force the state to IDLE and y_val to 0, with priority over start, a and b, including mid-pattern and in MATCH.
REQ-014 After reset is released, the first symbol sampled with start=1 SHALL be treated as pattern position 1.

Configuration
REQ-015 With macro STRING_TOP_OVERLAP_EN defined, matches SHALL overlap: MATCH on 11 -> G2, otherwise -> IDLE (the trailing 11 counts as the first symbol of the next match).
REQ-016 Without STRING_TOP_OVERLAP_EN, matches SHALL NOT overlap: MATCH behaves as IDLE (11 -> G1, otherwise -> IDLE).
REQ-017 The port list and reset behaviour SHALL be identical in both configurations.

Verification
REQ-018 The bench SHALL drive reset=0 for one edge, then reset=1, start=1, a=b=1 for 10 cycles, and require y_val=0 throughout.
REQ-019 The bench SHALL apply start=1 with symbols 11,11,01,11, and require y_val=1 for exactly the one cycle after the 4th edge, then 0.
REQ-020 The bench SHALL apply 11,11,01,11,11,01,11 and require two y_val pulses with STRING_TOP_OVERLAP_EN defined, and exactly one pulse without it.
REQ-021 The bench SHALL apply 11,11,01 then start=0 for one cycle, then 11, and require y_val to stay 0 (partial match cleared).
REQ-022 The bench SHALL apply 11,11,01, then reset=0 on the next edge while driving 11, and require y_val=0 and the state to be IDLE.
REQ-023 The bench SHALL apply 11,11,11,01,11 and require one y_val pulse after the last symbol (G2 self-loop).
